bit_serial_alu: RTL and testbench

//  Bit-serial ALU engine: latches two WIDTH-bit operands plus an ALU control code,

---
 rtl/bit_serial_alu.sv | 92 +++++++++
 tb/tb_bit_serial_alu.sv | 128 ++++++++++++
 2 files changed

// File: rtl/bit_serial_alu.sv
// bit_serial_alu: LSB-first bit-serial ALU (AND/OR/ADD/SUB/SLT), one bit per clock.
module bit_serial_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       alu_ctl,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q, b_q, acc;
    logic [2:0]       ctl;
    logic [IW-1:0]    idx;
    logic             c;

    logic             ai, bb, s, cn, ovf, arith, slt, bit_v, last;
    logic [WIDTH-1:0] full, final_res;

    always_comb begin
        ai        = a_q[idx];
        bb        = b_q[idx] ^ ctl[2];
        s         = ai ^ bb ^ c;
        cn        = (ai & bb) | (ai & c) | (bb & c);
        ovf       = c ^ cn;
        arith     = (ctl == 3'b010) || (ctl == 3'b110) || (ctl == 3'b111);
        slt       = ctl == 3'b111;
        bit_v     = (ctl == 3'b000) ? (ai & bb) : (ctl == 3'b001) ? (ai | bb) : arith ? s : 1'b0;
        full      = {bit_v, acc[WIDTH-1:1]};
        // SLT: sign of the true difference is the sum MSB corrected by overflow
        final_res = slt ? {{(WIDTH-1){1'b0}}, ovf ^ s} : full;
        last      = idx == LAST_IDX;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b1;
            a_q       <= '0;
            b_q       <= '0;
            ctl       <= '0;
            acc       <= '0;
            idx       <= '0;
            c         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    a_q   <= a;
                    b_q   <= b;
                    ctl   <= alu_ctl;
                    idx   <= '0;
                    c     <= alu_ctl[2];
                    busy  <= 1'b1;
                    state <= RUN;
                end
                RUN: begin
                    acc <= full;
                    c   <= cn;
                    idx <= idx + 1'b1;
                    if (last) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        result    <= final_res;
                        zero      <= final_res == '0;
                        carry_out <= arith & cn;
                        overflow  <= arith & ovf;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bit_serial_alu.sv
// tb_bit_serial_alu: table-driven directed checks plus busy-ignore and mid-run reset sequences.
module tb_bit_serial_alu;
    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic [2:0] alu_ctl = '0;
    logic       busy, done, carry_out, overflow, zero;
    logic [7:0] result;

    bit_serial_alu #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .alu_ctl(alu_ctl),
        .busy(busy), .done(done), .result(result), .carry_out(carry_out),
        .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [2:0] ctl;
        logic [7:0] x, y, res;
        logic       co, ov, z;
    } vec_t;

    int errs = 0, checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] cc, input logic [7:0] x, input logic [7:0] y);
        @(negedge clk);
        alu_ctl = cc; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = ~x; b = ~y; alu_ctl = ~cc;
    endtask

    task automatic run_op(input vec_t v);
        logic [7:0] prev;
        int n;
        prev = result;
        issue(v.ctl, v.x, v.y);
        chk({v.name, " busy"}, busy, 1);
        chk({v.name, " hold"}, result, prev);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!done && n < 40);
        chk({v.name, " latency"}, n, 8);
        chk({v.name, " result"}, result, v.res);
        chk({v.name, " carry"}, carry_out, v.co);
        chk({v.name, " ovf"}, overflow, v.ov);
        chk({v.name, " zero"}, zero, v.z);
        @(posedge clk); #1;
        chk({v.name, " done pulse"}, {busy, done}, 2'b00);
    endtask

    vec_t vecs[13];

    initial begin
        int ndone;
        logic [7:0] r;
        vecs[0]  = '{"add7f01", 3'b010, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{"sub0505", 3'b110, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{"sub0001", 3'b110, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{"slt8001", 3'b111, 8'h80, 8'h01, 8'h01, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{"slt7f80", 3'b111, 8'h7F, 8'h80, 8'h00, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{"slt0303", 3'b111, 8'h03, 8'h03, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{"and", 3'b000, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{"addff01", 3'b010, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{"bad011", 3'b011, 8'h12, 8'h34, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{"add4040", 3'b010, 8'h40, 8'h40, 8'h80, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{"bad101", 3'b101, 8'hF0, 8'h0F, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{"sub8001", 3'b110, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{"or", 3'b001, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0, 1'b0};

        #12;
        chk("reset outs", {busy, done, carry_out, overflow, zero}, 5'b00001);
        chk("reset result", result, 8'h00);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) run_op(vecs[i]);

        // start while busy must be dropped; operands changing mid-run must not matter
        issue(3'b010, 8'h10, 8'h20);
        repeat (2) @(negedge clk);
        chk("ignore busy", busy, 1);
        start = 1'b1; a = 8'h99; b = 8'h11; alu_ctl = 3'b110;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        r = '0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                r = result;
            end
        end
        chk("ignore ndone", ndone, 1);
        chk("ignore result", r, 8'h30);

        // asynchronous abort at idx=3
        issue(3'b010, 8'h7F, 8'h01);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort busy/done", {busy, done}, 2'b00);
        chk("abort result", result, 8'h00);
        chk("abort zero", zero, 1);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("abort no done", ndone, 0);
        run_op(vecs[0]);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
